// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encodings, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_X = 2'd3
   } lsu_size_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACC0  = 3'd1,
      WAIT0 = 3'd2,
      ACC1  = 3'd3,
      WAIT1 = 3'd4,
      RESP  = 3'd5
   } lsu_state_e;

   // Reserved size returns 0; such an access always faults before use.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_B:    size_bytes = 3'd1;
         SZ_H:    size_bytes = 3'd2;
         SZ_W:    size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// Handshakes: a transfer occurs on a rising edge where valid and ready are both 1;
// rsp_valid and mem_rvalid are single-cycle pulses with no ready.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault,
      output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
      input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store strobes and data for both
// halves of a possibly split access, and extraction/extension of load data.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [63:0] rdata64,
   output logic [3:0]  strb0,
   output logic [3:0]  strb1,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic [31:0] rdata_ext
);

   logic [3:0]  lane_mask;
   logic [7:0]  strb64;
   logic [63:0] wshift;
   logic [63:0] rshift;

   // Shifting across a 64-bit window gives both halves of a split access at once.
   always_comb begin
      case (size)
         SZ_B:    lane_mask = 4'b0001;
         SZ_H:    lane_mask = 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
      strb64 = {4'b0000, lane_mask} << off;
      wshift = {32'd0, wdata} << {off, 3'b000};
      rshift = rdata64 >> {off, 3'b000};
      case (size)
         SZ_B:    rdata_ext = is_unsigned ? {24'd0, rshift[7:0]}
                                          : {{24{rshift[7]}}, rshift[7:0]};
         SZ_H:    rdata_ext = is_unsigned ? {16'd0, rshift[15:0]}
                                          : {{16{rshift[15]}}, rshift[15:0]};
         default: rdata_ext = rshift[31:0];
      endcase
   end

   assign strb0  = strb64[3:0];
   assign strb1  = strb64[7:4];
   assign wdata0 = wshift[31:0];
   assign wdata1 = wshift[63:32];

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request at a time, misaligned accesses
// split into two word accesses, out-of-range accesses answered with a fault.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter longint unsigned MEM_BYTES = 64'd1048576
) (
   input  logic       clk,
   input  logic       rst_n,
   lsu_if.slave       bus,
   output lsu_state_e state_dbg
);

   lsu_state_e  state;
   logic        r_store, r_unsigned, r_split, r_fault;
   logic [1:0]  r_size, r_off;
   logic [31:0] r_wdata, rd_lo, rd_hi;
   logic        mem_valid_q, mem_we_q, rsp_valid_q, rsp_fault_q;
   logic [31:0] mem_addr_q, mem_wdata_q, rsp_rdata_q;
   logic [3:0]  mem_wstrb_q;

   logic [2:0]  req_n;
   logic [32:0] req_last;
   logic        req_fault, req_split, idle;
   logic [1:0]  a_size, a_off;
   logic [31:0] a_wdata, wdata0, wdata1, rdata_ext;
   logic [3:0]  strb0, strb1;

   // Last byte is computed with a carry bit so addresses near 2^32 cannot wrap.
   assign req_n     = size_bytes(bus.req_size);
   assign req_last  = {1'b0, bus.req_addr} + {30'd0, req_n} - 33'd1;
   assign req_fault = (bus.req_size == SZ_X) || (64'(req_last) >= MEM_BYTES);
   assign req_split = ({1'b0, bus.req_addr[1:0]} + req_n) > 3'd4;

   // In IDLE the first access is launched straight from the request fields.
   assign idle    = (state == IDLE);
   assign a_size  = idle ? bus.req_size       : r_size;
   assign a_off   = idle ? bus.req_addr[1:0]  : r_off;
   assign a_wdata = idle ? bus.req_wdata      : r_wdata;

   lsu_align u_align (
      .size        (a_size),
      .off         (a_off),
      .is_unsigned (r_unsigned),
      .wdata       (a_wdata),
      .rdata64     ({rd_hi, rd_lo}),
      .strb0       (strb0),
      .strb1       (strb1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .rdata_ext   (rdata_ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         r_store     <= 1'b0;
         r_unsigned  <= 1'b0;
         r_split     <= 1'b0;
         r_fault     <= 1'b0;
         r_size      <= 2'd0;
         r_off       <= 2'd0;
         r_wdata     <= 32'd0;
         rd_lo       <= 32'd0;
         rd_hi       <= 32'd0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wstrb_q <= 4'd0;
         mem_wdata_q <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_store    <= bus.req_store;
                  r_unsigned <= bus.req_unsigned;
                  r_size     <= bus.req_size;
                  r_off      <= bus.req_addr[1:0];
                  r_wdata    <= bus.req_wdata;
                  r_split    <= req_split;
                  r_fault    <= req_fault;
                  if (req_fault) begin
                     state <= RESP;
                  end else begin
                     state       <= ACC0;
                     mem_valid_q <= 1'b1;
                     mem_we_q    <= bus.req_store;
                     mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                     mem_wstrb_q <= bus.req_store ? strb0 : 4'hF;
                     mem_wdata_q <= wdata0;
                  end
               end
            end
            ACC0, ACC1: begin
               if (bus.mem_ready) begin
                  mem_valid_q <= 1'b0;
                  state       <= (state == ACC0) ? WAIT0 : WAIT1;
               end
            end
            WAIT0: begin
               if (bus.mem_rvalid) begin
                  rd_lo <= bus.mem_rdata;
                  if (r_split) begin
                     state       <= ACC1;
                     mem_valid_q <= 1'b1;
                     mem_addr_q  <= mem_addr_q + 32'd4;
                     mem_wstrb_q <= r_store ? strb1 : 4'hF;
                     mem_wdata_q <= wdata1;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            WAIT1: begin
               if (bus.mem_rvalid) begin
                  rd_hi <= bus.mem_rdata;
                  state <= RESP;
               end
            end
            RESP: begin
               rsp_valid_q <= 1'b1;
               rsp_fault_q <= r_fault;
               rsp_rdata_q <= (r_fault || r_store) ? 32'd0 : rdata_ext;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = idle;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_fault = rsp_fault_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses checked
// against a byte-level memory model.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam longint unsigned MEM_BYTES = 64'd1048576;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_if      bus ();
   lsu_state_e state_dbg;

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- memory images and scoreboard ----------------
   logic [7:0]  mem_img [logic [31:0]];
   logic [7:0]  ref_img [logic [31:0]];
   logic [31:0] exp_q [$];
   logic [31:0] acc_addr_q [$];
   logic [31:0] acc_wdata_q [$];
   logic [3:0]  acc_strb_q [$];
   logic        acc_we_q [$];
   int          mv_seen;
   int          stable_cmp;

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] img_rd(input logic [31:0] a);
      return mem_img.exists(a) ? mem_img[a] : dflt(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_img.exists(a) ? ref_img[a] : dflt(a);
   endfunction

   function automatic logic [31:0] img_word(input logic [31:0] a);
      return {img_rd(a + 32'd3), img_rd(a + 32'd2), img_rd(a + 32'd1), img_rd(a)};
   endfunction

   function automatic void preload_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         mem_img[a + 32'(i)] = w[8*i +: 8];
         ref_img[a + 32'(i)] = w[8*i +: 8];
      end
   endfunction

   // Reference: an access is a run of n bytes starting at addr, little-endian.
   function automatic void ref_access(input logic st, input logic [1:0] sz, input logic un,
                                      input logic [31:0] ad, input logic [31:0] wd,
                                      output logic flt, output logic [31:0] rd,
                                      output int nacc);
      int n;
      longint unsigned val;
      n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      flt  = (sz == 2'd3) || (64'(ad) + 64'(n) - 64'd1 >= MEM_BYTES);
      rd   = 32'd0;
      nacc = 0;
      if (!flt) begin
         nacc = (int'(ad[1:0]) + n > 4) ? 2 : 1;
         if (st) begin
            for (int i = 0; i < n; i++) ref_img[ad + 32'(i)] = wd[8*i +: 8];
         end else begin
            val = 0;
            for (int i = 0; i < n; i++) val = val | (64'(ref_rd(ad + 32'(i))) << (8*i));
            if (!un && n < 4 && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
            rd = val[31:0];
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      rst_n            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_store    = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'd0;
      bus.req_wdata    = 32'd0;
      bus.mem_ready    = 1'b0;
      bus.mem_rvalid   = 1'b0;
      bus.mem_rdata    = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issues one request and plays the memory: stall cycles of mem_ready=0 per
   // access, then the acknowledge rdly cycles after the earliest possible slot.
   task automatic do_access(input logic st, input logic [1:0] sz, input logic un,
                            input logic [31:0] ad, input logic [31:0] wd,
                            input int stall, input int rdly,
                            output int lat, output logic [31:0] rdata,
                            output logic fault, output logic done);
      int c, stall_left, pend;
      logic snapped;
      logic [31:0] snap_addr, snap_wdata;
      logic [3:0]  snap_strb;
      acc_addr_q.delete(); acc_wdata_q.delete(); acc_strb_q.delete(); acc_we_q.delete();
      mv_seen = 0; lat = -1; rdata = 32'd0; fault = 1'b0; done = 1'b0;
      c = 0; stall_left = stall; pend = 0; snapped = 1'b0;
      snap_addr = 32'd0; snap_wdata = 32'd0; snap_strb = 4'd0;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL req_ready_idle: got %b expected 1", bus.req_ready);
      end
      bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
      bus.req_unsigned = un; bus.req_addr = ad; bus.req_wdata = wd;
      @(posedge clk);
      while (!done && c < 80) begin
         @(negedge clk);
         bus.req_valid  = 1'b0;
         bus.mem_rvalid = 1'b0;
         bus.mem_ready  = 1'b0;
         if (bus.rsp_valid === 1'b1) begin
            done = 1'b1; lat = c; rdata = bus.rsp_rdata; fault = bus.rsp_fault;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = img_word(acc_addr_q[$]);
               end
            end
            if (bus.mem_valid === 1'b1) begin
               mv_seen++;
               if (!snapped) begin
                  snapped = 1'b1; snap_addr = bus.mem_addr;
                  snap_strb = bus.mem_wstrb; snap_wdata = bus.mem_wdata;
               end else begin
                  n_cmp++; stable_cmp++;
                  if (bus.mem_addr !== snap_addr || bus.mem_wstrb !== snap_strb ||
                      bus.mem_wdata !== snap_wdata) begin
                     n_err++;
                     $display("FAIL mem_stable: got %h/%b/%h expected %h/%b/%h",
                              bus.mem_addr, bus.mem_wstrb, bus.mem_wdata,
                              snap_addr, snap_strb, snap_wdata);
                  end
               end
               if (stall_left > 0) begin
                  stall_left--;
                  if (!bus.mem_rvalid && $urandom_range(0, 1) == 1) begin
                     bus.mem_rvalid = 1'b1;
                     bus.mem_rdata  = $urandom;
                  end
               end else begin
                  bus.mem_ready = 1'b1;
                  acc_addr_q.push_back(bus.mem_addr);
                  acc_strb_q.push_back(bus.mem_wstrb);
                  acc_wdata_q.push_back(bus.mem_wdata);
                  acc_we_q.push_back(bus.mem_we);
                  if (bus.mem_we === 1'b1)
                     for (int i = 0; i < 4; i++)
                        if (bus.mem_wstrb[i]) mem_img[bus.mem_addr + 32'(i)] = bus.mem_wdata[8*i +: 8];
                  pend = rdly + 1; snapped = 1'b0; stall_left = stall;
               end
            end
         end
         if (!done) begin
            @(posedge clk);
            c++;
         end
      end
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL rsp_timeout: got no rsp_valid expected one within 80 cycles");
         apply_reset();
      end else begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_pulse: got rsp_valid=%b expected 0 after one cycle", bus.rsp_valid);
         end
      end
   endtask

   // Runs one access and checks everything the reference model predicts.
   task automatic check_vs_ref(input string name, input logic st, input logic [1:0] sz,
                               input logic un, input logic [31:0] ad, input logic [31:0] wd,
                               input int stall, input int rdly);
      logic exp_flt, got_flt, done, img_ok;
      logic [31:0] exp_rd, got_rd, exp_a;
      int exp_n, exp_lat, got_lat;
      ref_access(st, sz, un, ad, wd, exp_flt, exp_rd, exp_n);
      exp_q.push_back(exp_rd);
      exp_lat = exp_flt ? 1 : exp_n * (stall + rdly + 2) + 1;
      do_access(st, sz, un, ad, wd, stall, rdly, got_lat, got_rd, got_flt, done);
      exp_rd = exp_q.pop_front();
      if (!done) return;
      n_cmp++;
      if (got_rd !== exp_rd) begin
         n_err++; $display("FAIL %s_rdata: got %h expected %h", name, got_rd, exp_rd);
      end
      n_cmp++;
      if (got_flt !== exp_flt) begin
         n_err++; $display("FAIL %s_fault: got %b expected %b", name, got_flt, exp_flt);
      end
      n_cmp++;
      if (got_lat != exp_lat) begin
         n_err++; $display("FAIL %s_latency: got %0d expected %0d", name, got_lat, exp_lat);
      end
      n_cmp++;
      if (acc_addr_q.size() != exp_n) begin
         n_err++; $display("FAIL %s_accesses: got %0d expected %0d", name, acc_addr_q.size(), exp_n);
      end
      for (int k = 0; k < acc_addr_q.size() && k < exp_n; k++) begin
         exp_a = {ad[31:2], 2'b00} + 32'(4 * k);
         n_cmp++;
         if (acc_addr_q[k] !== exp_a || acc_we_q[k] !== st || (!st && acc_strb_q[k] !== 4'hF)) begin
            n_err++;
            $display("FAIL %s_acc%0d: got addr %h we %b strb %b expected addr %h we %b",
                     name, k, acc_addr_q[k], acc_we_q[k], acc_strb_q[k], exp_a, st);
         end
      end
      if (st && !exp_flt) begin
         img_ok = 1'b1;
         for (int i = -4; i < 12; i++) begin
            exp_a = {ad[31:2], 2'b00} + 32'(i);
            if (img_rd(exp_a) !== ref_rd(exp_a)) img_ok = 1'b0;
         end
         n_cmp++;
         if (!img_ok) begin
            n_err++; $display("FAIL %s_mem_image: got bytes differing near %h expected model bytes", name, ad);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if (bus.req_ready !== 1'b1 || state_dbg !== IDLE) begin
         n_err++; $display("FAIL reset_ready: got %b state %0d expected 1 state 0", bus.req_ready, state_dbg);
      end
      n_cmp++;
      if ({bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.rsp_valid, bus.rsp_fault} !== 8'd0 ||
          bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.rsp_rdata !== 32'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got mv %b we %b strb %b addr %h wd %h rv %b rf %b rd %h expected all 0",
                  bus.mem_valid, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata,
                  bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata);
      end
   endtask

   task automatic test_aligned_load();
      preload_word(32'h100, 32'hDEADBEEF);
      check_vs_ref("lw_aligned", 1'b0, SZ_W, 1'b0, 32'h100, 32'd0, 0, 0);
   endtask

   task automatic test_byte_load();
      int lat; logic [31:0] rd; logic flt, done;
      preload_word(32'h100, 32'h80112233);
      do_access(1'b0, SZ_B, 1'b0, 32'h103, 32'd0, 0, 0, lat, rd, flt, done);
      n_cmp++;
      if (rd !== 32'hFFFFFF80) begin
         n_err++; $display("FAIL lb_signed: got %h expected ffffff80", rd);
      end
      do_access(1'b0, SZ_B, 1'b1, 32'h103, 32'd0, 0, 0, lat, rd, flt, done);
      n_cmp++;
      if (rd !== 32'h00000080) begin
         n_err++; $display("FAIL lbu_unsigned: got %h expected 00000080", rd);
      end
   endtask

   task automatic test_split_store();
      check_vs_ref("sw_split", 1'b1, SZ_W, 1'b0, 32'h102, 32'hAABBCCDD, 0, 0);
      n_cmp++;
      if (acc_addr_q.size() != 2 ||
          acc_strb_q[0] !== 4'b1100 || acc_wdata_q[0] !== 32'hCCDD0000 ||
          acc_strb_q[1] !== 4'b0011 || acc_wdata_q[1] !== 32'h0000AABB) begin
         n_err++;
         $display("FAIL sw_split_lanes: got %0d accesses expected strb 1100/0011 wdata ccdd0000/0000aabb",
                  acc_addr_q.size());
      end
   endtask

   task automatic test_fault();
      check_vs_ref("lh_fault", 1'b0, SZ_H, 1'b0, 32'h000FFFFF, 32'd0, 0, 0);
      n_cmp++;
      if (mv_seen != 0) begin
         n_err++; $display("FAIL fault_no_mem: got mem_valid in %0d cycles expected 0", mv_seen);
      end
   endtask

   task automatic test_boundary();
      check_vs_ref("lw_top",    1'b0, SZ_W, 1'b0, 32'h000FFFFC, 32'd0, 0, 0);
      check_vs_ref("lb_top",    1'b0, SZ_B, 1'b0, 32'h000FFFFF, 32'd0, 0, 0);
      check_vs_ref("sh_top",    1'b1, SZ_H, 1'b0, 32'h000FFFFE, 32'h1234, 0, 1);
      check_vs_ref("lw_over",   1'b0, SZ_W, 1'b0, 32'h000FFFFE, 32'd0, 0, 0);
      check_vs_ref("lb_past",   1'b0, SZ_B, 1'b1, 32'h00100000, 32'd0, 0, 0);
      check_vs_ref("lw_wrap",   1'b0, SZ_W, 1'b0, 32'hFFFFFFFE, 32'd0, 0, 0);
      check_vs_ref("size_rsv",  1'b1, 2'd3, 1'b0, 32'h00000010, 32'd5, 0, 0);
   endtask

   task automatic test_backpressure();
      stable_cmp = 0;
      check_vs_ref("lw_stall4", 1'b0, SZ_W, 1'b0, 32'h100, 32'd0, 4, 0);
      n_cmp++;
      if (stable_cmp != 4) begin
         n_err++; $display("FAIL stall_observed: got %0d stable checks expected 4", stable_cmp);
      end
   endtask

   task automatic test_reset_mid();
      logic quiet;
      // Reset while the first access is being offered.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = SZ_W; bus.req_addr = 32'h200;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.mem_valid !== 1'b0 || state_dbg !== IDLE) begin
         n_err++; $display("FAIL reset_acc0: got mem_valid %b state %0d expected 0 state 0", bus.mem_valid, state_dbg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Reset while waiting for the acknowledge; the acknowledge arrives late.
      @(negedge clk);
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      rst_n = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
      #1;
      n_cmp++;
      if (bus.mem_valid !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_wait0: got mem_valid %b rsp_valid %b expected 0 0", bus.mem_valid, bus.rsp_valid);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_err++; $display("FAIL ready_after_reset: got %b expected 1", bus.req_ready);
      end
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         bus.mem_rvalid = 1'b0;
         if (bus.rsp_valid !== 1'b0 || bus.mem_valid !== 1'b0 || state_dbg !== IDLE) quiet = 1'b0;
      end
      n_cmp++;
      if (!quiet) begin
         n_err++; $display("FAIL late_rvalid: got activity after reset expected idle and no rsp_valid");
      end
   endtask

   task automatic test_random();
      logic st, un;
      logic [1:0] sz;
      logic [31:0] ad;
      int r;
      for (int it = 0; it < 150; it++) begin
         st = 1'($urandom_range(0, 1));
         un = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r  = $urandom_range(0, 9);
         if (r < 7)      ad = 32'($urandom_range(0, 511));
         else if (r < 9) ad = 32'(MEM_BYTES) - 32'd6 + 32'($urandom_range(0, 9));
         else            ad = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
         check_vs_ref("rand", st, sz, un, ad, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_aligned_load();
      test_byte_load();
      test_split_store();
      test_fault();
      test_boundary();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before 2000000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
